// File: rtl/mole_round_ctrl.sv
// mole_round_ctrl: round sequencing, step/second dividers and difficulty for the mole generator
// Ports:
//   i_clk          system clock, all state on rising edge
//   i_rst_n        asynchronous active-low reset
//   i_start        level, begins a round from IDLE or DONE
//   i_pause        level, freezes the round while high in RUN
//   o_rand_reset   reset to the random generator, high for one edge after reset release
//   o_load_lfsr    seed-load strobe (SEED)
//   o_lfsr_shift   LFSR advance enable (WARM, unpaused RUN)
//   o_seq_shift    one-cycle column-sequence shift pulse
//   o_round_active high in RUN, including while paused
//   o_done         high in DONE
//   o_level        difficulty 0..3
//   o_time_left    seconds remaining in the round
module mole_round_ctrl #(
    parameter int BASE_DIV  = 25000000,
    parameter int SEC_DIV   = 50000000,
    parameter int ROUND_SEC = 60,
    parameter int LEVEL_UP  = 16,
    parameter int WARMUP    = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_pause,
    output logic       o_rand_reset,
    output logic       o_load_lfsr,
    output logic       o_lfsr_shift,
    output logic       o_seq_shift,
    output logic       o_round_active,
    output logic       o_done,
    output logic [1:0] o_level,
    output logic [7:0] o_time_left
);
    localparam int SW = $clog2(BASE_DIV);
    localparam int CW = $clog2(SEC_DIV);
    localparam int KW = $clog2(LEVEL_UP + 1);
    localparam int WW = $clog2(WARMUP + 1);

    typedef enum logic [2:0] {S_IDLE, S_SEED, S_WARM, S_RUN, S_DONE} state_t;

    state_t        r_state, w_next;
    logic [SW-1:0] r_step_div;
    logic [CW-1:0] r_sec_div;
    logic [KW-1:0] r_steps;
    logic [WW-1:0] r_warm;
    logic [1:0]    r_level;
    logic [7:0]    r_time_left;
    logic          r_rand_reset, r_seq_shift;
    logic          w_tick, w_step_wrap, w_sec_wrap;

    // pause outranks every terminal count: nothing advances while it is high
    assign w_tick      = (r_state == S_RUN) && !i_pause;
    // step period shrinks by half per level; the compare picks up a new level on the following count
    assign w_step_wrap = w_tick && (int'(r_step_div) == (BASE_DIV >> r_level) - 1);
    assign w_sec_wrap  = w_tick && (int'(r_sec_div) == SEC_DIV - 1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next         = r_state;
        o_load_lfsr    = r_state == S_SEED;
        o_lfsr_shift   = (r_state == S_WARM) || w_tick;
        o_round_active = r_state == S_RUN;
        o_done         = r_state == S_DONE;
        case (r_state)
            S_IDLE:  w_next = (i_start && !r_rand_reset) ? S_SEED : S_IDLE;
            S_SEED:  w_next = S_WARM;
            S_WARM:  w_next = (int'(r_warm) == WARMUP - 1) ? S_RUN : S_WARM;
            S_RUN:   w_next = (w_sec_wrap && r_time_left == 8'd1) ? S_DONE : S_RUN;
            S_DONE:  w_next = i_start ? S_SEED : S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rand_reset <= 1'b1;
            r_seq_shift  <= 1'b0;
            r_warm       <= '0;
            r_step_div   <= '0;
            r_sec_div    <= '0;
            r_steps      <= '0;
            r_level      <= 2'd0;
            r_time_left  <= 8'(ROUND_SEC);
        end else begin
            r_rand_reset <= 1'b0;
            // a wrap on the final second still pulses, landing in the first DONE cycle
            r_seq_shift  <= w_step_wrap;
            r_warm       <= (r_state == S_WARM) ? r_warm + 1'b1 : '0;
            if (w_next == S_SEED) begin
                r_step_div  <= '0;
                r_sec_div   <= '0;
                r_steps     <= '0;
                r_level     <= 2'd0;
                r_time_left <= 8'(ROUND_SEC);
            end else begin
                if (w_step_wrap) begin
                    r_step_div <= '0;
                    r_steps    <= (int'(r_steps) == LEVEL_UP - 1) ? '0 : r_steps + 1'b1;
                    if (int'(r_steps) == LEVEL_UP - 1)
                        r_level <= (r_level == 2'd3) ? 2'd3 : r_level + 2'd1;
                end else if (w_tick) begin
                    r_step_div <= r_step_div + 1'b1;
                end
                if (w_sec_wrap) begin
                    r_sec_div   <= '0;
                    r_time_left <= r_time_left - 8'd1;
                end else if (w_tick) begin
                    r_sec_div <= r_sec_div + 1'b1;
                end
            end
        end
    end

    assign o_rand_reset = r_rand_reset;
    assign o_seq_shift  = r_seq_shift;
    assign o_level      = r_level;
    assign o_time_left  = r_time_left;
endmodule

// File: tb/tb_mole_round_ctrl.sv
// tb_mole_round_ctrl: scoreboard bench for mole_round_ctrl against an event-time reference model
module tb_mole_round_ctrl;
  localparam int BASE_DIV = 8;
  localparam int SEC_DIV = 20;
  localparam int ROUND_SEC = 3;
  localparam int LEVEL_UP = 4;
  localparam int WARMUP = 4;
  localparam int P_IDLE = 0, P_SEED = 1, P_WARM = 2, P_RUN = 3, P_DONE = 4;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, pause = 1'b0;
  logic rand_reset, load_lfsr, lfsr_shift, seq_shift, round_active, done;
  logic [1:0] level;
  logic [7:0] time_left;
  mole_round_ctrl #(
    .BASE_DIV(BASE_DIV), .SEC_DIV(SEC_DIV), .ROUND_SEC(ROUND_SEC),
    .LEVEL_UP(LEVEL_UP), .WARMUP(WARMUP)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_pause(pause),
    .o_rand_reset(rand_reset), .o_load_lfsr(load_lfsr), .o_lfsr_shift(lfsr_shift),
    .o_seq_shift(seq_shift), .o_round_active(round_active), .o_done(done),
    .o_level(level), .o_time_left(time_left)
  );
  always #5 clk = ~clk;
  typedef struct { int cyc; logic [15:0] v; } exp_t;
  exp_t sb[$];
  exp_t e;
  logic [15:0] got;
  int n_cmp = 0, n_bad = 0, cyc_n = 0, pb = 0, wait_n = 0;
  int ph, warm_left, act, wraps, next_wrap;
  bit m_rr, m_seq;
  function automatic int lvl();
    return (wraps / LEVEL_UP > 3) ? 3 : wraps / LEVEL_UP;
  endfunction
  function automatic void m_reset();
    ph = P_IDLE; m_rr = 1; m_seq = 0; act = 0; wraps = 0; warm_left = 0; next_wrap = BASE_DIV - 1;
  endfunction
  function automatic void begin_round();
    ph = P_SEED; act = 0; wraps = 0; next_wrap = BASE_DIV - 1;
  endfunction
  function automatic void m_step(bit s, bit p);
    bit rr = m_rr;
    m_rr = 0;
    m_seq = 0;
    case (ph)
      P_IDLE: if (s && !rr) begin_round();
      P_SEED: begin ph = P_WARM; warm_left = WARMUP; end
      P_WARM: begin warm_left--; if (warm_left == 0) ph = P_RUN; end
      P_RUN: if (!p) begin
        if (act == next_wrap) begin
          wraps++;
          m_seq = 1;
          next_wrap = act + (BASE_DIV >> lvl());
        end
        act++;
        if (act == ROUND_SEC * SEC_DIV) ph = P_DONE;
      end
      P_DONE: if (s) begin_round();
      default: ;
    endcase
  endfunction
  function automatic logic [15:0] exp_vec();
    int t = ROUND_SEC - act / SEC_DIV;
    return {m_rr, ph == P_SEED, (ph == P_WARM) || (ph == P_RUN && !pause), m_seq,
            ph == P_RUN, ph == P_DONE, 2'(lvl()), 8'(t)};
  endfunction
  task automatic cyc(input bit s, input bit p, input bit rst);
    start = s;
    pause = p;
    if (rst) begin
      rst_n = 1'b0;
      #1;
      m_reset();
    end else begin
      rst_n = 1'b1;
    end
    sb.push_back('{cyc_n, exp_vec()});
    @(posedge clk);
    if (!rst_n) m_reset(); else m_step(s, p);
    cyc_n++;
    #1;
  endtask
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      got = {rand_reset, load_lfsr, lfsr_shift, seq_shift, round_active, done, level, time_left};
      n_cmp++;
      if (got !== e.v) begin
        n_bad++;
        $display("FAIL cyc%0d outputs: got rr=%b ld=%b sh=%b seq=%b act=%b done=%b lvl=%0d tl=%0d, want rr=%b ld=%b sh=%b seq=%b act=%b done=%b lvl=%0d tl=%0d",
                 e.cyc, got[15], got[14], got[13], got[12], got[11], got[10], got[9:8], got[7:0],
                 e.v[15], e.v[14], e.v[13], e.v[12], e.v[11], e.v[10], e.v[9:8], e.v[7:0]);
      end
    end
  end
  initial begin
    m_reset();
    @(posedge clk);
    #1;
    n_cmp++;
    if ({rand_reset, load_lfsr, lfsr_shift, seq_shift, round_active, done, level, time_left} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'(ROUND_SEC)}) begin
      n_bad++;
      $display("FAIL reset state: rr=%b ld=%b sh=%b seq=%b act=%b done=%b lvl=%0d tl=%0d",
               rand_reset, load_lfsr, lfsr_shift, seq_shift, round_active, done, level, time_left);
    end
    repeat (2) cyc(0, 0, 1);
    cyc(1, 0, 0);
    repeat (2) cyc(0, 0, 0);
    cyc(1, 0, 0);
    wait_n = 0;
    while (!done && wait_n < 100) begin
      cyc(0, 0, 0);
      wait_n++;
    end
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL timeout: done not asserted within %0d cycles of start", wait_n);
    end
    repeat (15) cyc(0, 0, 0);
    cyc(1, 0, 0);
    repeat (30) cyc(0, 0, 0);
    repeat (10) cyc(0, 1, 0);
    repeat (80) cyc($urandom_range(0, 1) == 1, 0, 0);
    repeat (2) cyc(0, 0, 1);
    repeat (2) cyc(0, 0, 0);
    cyc(1, 0, 0);
    repeat (2) cyc(0, 0, 0);
    repeat (2) cyc(0, 0, 1);
    repeat (3) cyc(0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      if (pb == 0 && $urandom_range(0, 15) == 0) pb = $urandom_range(1, 12);
      cyc($urandom_range(0, 9) == 0, pb > 0, $urandom_range(0, 599) == 0);
      if (pb > 0) pb--;
    end
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
